// File: rtl/reg_file_dp.sv
// reg_file_dp: general-purpose register file, 2 write ports / 2 combinational
// read ports, entry 0 hardwired to zero, optional same-cycle write bypass and
// a hardware clear sweep that zeroes entries 1..DEPTH-1 after reset or on
// request.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   clr_req             one-cycle request to (re)start the clear sweep
//   wen0/waddr0/wdata0  write port 0
//   wen1/waddr1/wdata1  write port 1 (wins over port 0 on equal address)
//   raddr1/rdata1       read port 1 (combinational)
//   raddr2/rdata2       read port 2 (combinational)
//   init_busy           high while the clear sweep runs
module reg_file_dp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  wen0,
  input  logic [ADDR_WIDTH-1:0] waddr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  wen1,
  input  logic [ADDR_WIDTH-1:0] waddr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Qualified write strobes; address 0 is never stored.
  logic we0, we1;
  assign we1 = (state == READY) && wen1 && (waddr1 != '0);
  // Port 1 wins a same-address collision, so port 0 is suppressed.
  assign we0 = (state == READY) && wen0 && (waddr0 != '0) &&
               !(wen1 && (waddr1 == waddr0));

  // Sweep control. init_busy is registered and tracks the next state so it
  // is high exactly while state == CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= ADDR_WIDTH'(1);
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_req) begin
            clr_idx <= ADDR_WIDTH'(1);
          end else if (clr_idx == '1) begin
            state     <= READY;
            init_busy <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            state     <= CLEAR;
            clr_idx   <= ADDR_WIDTH'(1);
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= CLEAR;
          clr_idx   <= ADDR_WIDTH'(1);
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep provides the zero contents.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else begin
      if (we1) mem[waddr1] <= wdata1;
      if (we0) mem[waddr0] <= wdata0;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_port(input logic [ADDR_WIDTH-1:0] ra);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (!rst && state == READY && ra != '0) begin
      if (BYPASS != 0 && wen1 && waddr1 == ra)      v = wdata1;
      else if (BYPASS != 0 && wen0 && waddr0 == ra) v = wdata0;
      else                                          v = mem[ra];
    end
    return v;
  endfunction

  always_comb begin
    rdata1 = rd_port(raddr1);
    rdata2 = rd_port(raddr2);
  end

endmodule

// File: tb/tb_reg_file_dp.sv
module tb_reg_file_dp;

  logic        clk = 1'b0;
  logic        rst, clr_req;
  logic        wen0, wen1;
  logic [4:0]  waddr0, waddr1, raddr1, raddr2;
  logic [31:0] wdata0, wdata1;
  logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
  logic        init_busy, nb_init_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .init_busy(init_busy)
  );

  // Same stimulus, no bypass.
  reg_file_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(nb_rdata1), .rdata2(nb_rdata2), .init_busy(nb_init_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count posedges until init_busy drops (bounded); checks reads stay 0.
  task automatic sweep_len(input string tag);
    int n;
    n = 0;
    raddr1 = 5'd5;
    do begin
      tick();
      n++;
      if (init_busy) chk({tag, "_rd0"}, rdata1, 32'h0);
    end while (init_busy && n < 40);
    chk({tag, "_len"}, n, 31);
    chk({tag, "_nb_busy"}, {31'b0, nb_init_busy}, 32'h0);
  endtask

  task automatic all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      raddr1 = a[4:0];
      raddr2 = 5'(31 - a);
      #1;
      chk(tag, rdata1, 32'h0);
      chk(tag, rdata2, 32'h0);
    end
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    wen0 = 1'b1; waddr0 = a; wdata0 = d;
    tick();
    wen0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0;
    wen0 = 1'b0; wen1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr1 = 5'd5; raddr2 = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'b0, init_busy}, 32'h1);
    chk("rst_rd", rdata1, 32'h0);

    // Sweep after release, with a write attempt held throughout
    rst = 1'b0;
    wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h55;
    sweep_len("sweep");
    wen0 = 1'b0;
    all_zero("post_sweep");
    raddr1 = 5'd3; #1;
    chk("sweep_wr_ign", rdata1, 32'h0);

    // Basic write/read
    wr0(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5; #1;
    chk("basic_rd", rdata1, 32'hDEADBEEF);
    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h12345678; raddr2 = 5'd0; #1;
    chk("a0_bypass", rdata2, 32'h0);
    tick();
    wen0 = 1'b0; #1;
    chk("a0_rd", rdata2, 32'h0);

    // Dual-write collision, then distinct addresses
    wen0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1111;
    wen1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h2222;
    tick();
    wen0 = 1'b0; wen1 = 1'b0; raddr1 = 5'd9; #1;
    chk("collide", rdata1, 32'h2222);
    wen0 = 1'b1; waddr0 = 5'd9;  wdata0 = 32'h1111;
    wen1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'h2222;
    tick();
    wen0 = 1'b0; wen1 = 1'b0; raddr1 = 5'd9; raddr2 = 5'd10; #1;
    chk("dual_a9", rdata1, 32'h1111);
    chk("dual_a10", rdata2, 32'h2222);

    // Bypass vs. no-bypass
    wr0(5'd7, 32'hAAAA);
    wen0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hBBBB; raddr1 = 5'd7; #1;
    chk("byp_p0", rdata1, 32'hBBBB);
    chk("nobyp_p0", nb_rdata1, 32'hAAAA);
    wen1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hCCCC; #1;
    chk("byp_p1", rdata1, 32'hCCCC);
    chk("nobyp_p1", nb_rdata1, 32'hAAAA);
    wen0 = 1'b0; wen1 = 1'b0;
    tick();
    chk("no_write", rdata1, 32'hAAAA);

    // Fill, then clr_req sweep
    for (int a = 1; a < 32; a++) wr0(5'(a), 32'hA5000000 | 32'(a));
    raddr1 = 5'd31; raddr2 = 5'd1; #1;
    chk("fill_a31", rdata1, 32'hA500001F);
    chk("fill_a1", rdata2, 32'hA5000001);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("clr_busy", {31'b0, init_busy}, 32'h1);
    sweep_len("clr");
    all_zero("post_clr");

    // Mid-sweep reset: entry 20 is still dirty at sweep cycle 10
    wr0(5'd20, 32'h20202020);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; #1;
    chk("mid_rst_busy", {31'b0, init_busy}, 32'h1);
    tick();
    rst = 1'b0;
    sweep_len("re_sweep");
    raddr1 = 5'd20; #1;
    chk("re_clr_a20", rdata1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_dp.md
Name: reg_file_dp

Overview:
- Next-generation general-purpose register file for the CPU datapath.
- Parametrised in data width and address width, with two write ports (e.g. ALU writeback plus load writeback) and two combinational read ports.
- Adds optional write-to-read bypass and a hardware clear sweep that zeroes every entry after reset or on request, reporting progress on `init_busy`.
- Entry 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32: width of each register and of all data ports.
- ADDR_WIDTH, 5: address width; DEPTH = 2**ADDR_WIDTH entries.
- BYPASS, 1: 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- clr_req  input  1  single-cycle request to restart the clear sweep.
- wen0  input  1  write enable, port 0.
- waddr0  input  ADDR_WIDTH  write address, port 0.
- wdata0  input  DATA_WIDTH  write data, port 0.
- wen1  input  1  write enable, port 1 (priority port).
- waddr1  input  ADDR_WIDTH  write address, port 1.
- wdata1  input  DATA_WIDTH  write data, port 1.
- raddr1  input  ADDR_WIDTH  read address, port 1.
- raddr2  input  ADDR_WIDTH  read address, port 2.
- rdata1  output  DATA_WIDTH  read data, port 1 (combinational).
- rdata2  output  DATA_WIDTH  read data, port 2 (combinational).
- init_busy  output  1  high while the clear sweep is in progress.

Behaviour:
- FSM states: CLEAR, READY. Sweep counter `clr_idx` is ADDR_WIDTH bits.
- rst high (asynchronous):
  - state = CLEAR, clr_idx = 1, init_busy = 1.
  - rdata1/rdata2 = 0 while rst is high.
  - The storage array itself has no asynchronous reset.
- CLEAR state:
  - Each posedge writes 0 to entry clr_idx, then clr_idx increments.
  - When clr_idx == DEPTH-1 is written, the next state is READY.
  - The sweep takes DEPTH-1 cycles after rst deasserts (31 cycles at defaults).
  - init_busy = 1 for the whole state.
  - wen0/wen1 are ignored.
  - rdata1/rdata2 = 0 regardless of address.
- READY state:
  - init_busy = 0.
  - Writes commit on posedge when wen is high and waddr != 0.
  - Writes with waddr == 0 are dropped.
- Both write ports enabled with equal nonzero address: port 1 data is stored and port 0 is discarded.
- Different addresses on the two ports: both are written in the same cycle.
- Reads:
  - rdata = 0 when raddr == 0.
  - Otherwise rdata = stored value.
  - When BYPASS = 1 and in READY, a matching same-cycle write is forwarded instead: wen1 && waddr1 == raddr gives wdata1; else wen0 && waddr0 == raddr gives wdata0; else the stored value.
  - Bypass never applies to address 0.
- clr_req in READY:
  - Next state = CLEAR, clr_idx = 1.
  - Writes presented in that same cycle still commit.
- clr_req in CLEAR: the sweep restarts with clr_idx = 1.
- Reset asserted mid-sweep or mid-operation: the sweep restarts from index 1; partially cleared entries are re-cleared.
- Latency:
  - Write-to-read through storage is 1 cycle.
  - Write-to-read through bypass is 0 cycles.
- All widths are exact; no truncation or extension is performed on data.

Test Plan:
- Reset/sweep: pulse rst for 2 cycles, release.
  - init_busy stays 1 for exactly 31 posedges, then drops to 0.
  - rdata1 = 0 throughout the sweep.
  - Afterwards, reads of every address 0..31 return 0.
- Basic write/read:
  - Cycle N: wen0 = 1, waddr0 = 5, wdata0 = 0xDEADBEEF.
  - Cycle N+1: raddr1 = 5 gives rdata1 = 0xDEADBEEF.
  - Write 0x12345678 to address 0, then raddr2 = 0 gives rdata2 = 0.
- Dual write collision: wen0 = wen1 = 1, waddr0 = waddr1 = 9, wdata0 = 0x1111, wdata1 = 0x2222.
  - Next cycle, address 9 reads 0x2222.
  - Repeat with addresses 9 and 10: both are written.
- Bypass (BYPASS = 1):
  - Address 7 holds 0xAAAA.
  - Same cycle as wen0 = 1, waddr0 = 7, wdata0 = 0xBBBB with raddr1 = 7: rdata1 = 0xBBBB.
  - Add wen1 to 7 with wdata1 = 0xCCCC: rdata1 = 0xCCCC.
  - With BYPASS = 0, the same stimulus gives 0xAAAA.
- Writes during sweep: issue wen0 = 1, waddr0 = 3, wdata0 = 0x55 while init_busy = 1.
  - After the sweep completes, address 3 reads 0.
- clr_req / mid-sweep reset:
  - Fill addresses 1..31 with nonzero data, pulse clr_req: all entries read 0 after 31 cycles.
  - Assert rst at sweep cycle 10: the sweep restarts and init_busy lasts 31 cycles after release.
